mult_arbiter: RTL and testbench

Shares one 4x4 shift-add multiplier between two requesters with round-robin arbitration and valid/ready handshakes on both the request and response sides. It sits between two operand producers and one result consumer. It contains the sequential multiplier datapath (one partial-product step per cycle) and the control FSM that sequences it. Results carry a requester ID so the consumer can route them.

---
 rtl/mult_arbiter.sv | 124 ++++++++++++
 tb/tb_mult_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one 4x4 shift-add multiplier.
// Each accepted operation spends 4 cycles in CALC and then holds its result until it is taken.
module mult_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_p,
  output logic       resp_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        prio_q;
  logic        id_q;
  logic [7:0]  acc_q;
  logic [7:0]  mcand_q;
  logic [3:0]  mplier_q;
  logic [1:0]  step_q;
  logic        resp_valid_q;
  logic        busy_q;

  logic        any_valid_s;
  logic        grant_s;
  logic [3:0]  sel_a_s;
  logic [3:0]  sel_b_s;

  // Grant and operand select; the pointer only breaks ties
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_s = prio_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      sel_a_s = req1_a;
      sel_b_s = req1_b;
    end else begin
      sel_a_s = req0_a;
      sel_b_s = req0_b;
    end
  end

  assign req0_ready = (state_q == IDLE) && any_valid_s && !grant_s;
  assign req1_ready = (state_q == IDLE) && any_valid_s &&  grant_s;

  assign resp_valid = resp_valid_q;
  assign resp_p     = acc_q;
  assign resp_id    = id_q;
  assign busy       = busy_q;

  // Control FSM and multiplier datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      acc_q        <= 8'd0;
      mcand_q      <= 8'd0;
      mplier_q     <= 4'd0;
      step_q       <= 2'd0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid_s) begin
            mcand_q  <= {4'd0, sel_a_s};
            mplier_q <= sel_b_s;
            acc_q    <= 8'd0;
            step_q   <= 2'd0;
            id_q     <= grant_s;
            prio_q   <= ~grant_s;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          // Max product is 225, so the accumulator never overflows
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          step_q   <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = 4'd0;
  logic [3:0] req0_b = 4'd0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = 4'd0;
  logic [3:0] req1_b = 4'd0;
  logic       req1_ready;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [7:0] resp_p;
  logic       resp_id;
  logic       busy;

  int checks = 0;
  int failures = 0;

  mult_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_p(resp_p), .resp_id(resp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a falling edge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Transaction model: one job in flight, response visible 4 cycles after accept
  bit         m_init = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_prio = 1'b0;
  bit         m_id   = 1'b0;
  bit         m_zero = 1'b1;
  int         m_cnt  = 0;
  logic [7:0] m_p    = 8'd0;

  function automatic bit pick(input bit v0, input bit v1, input bit pr);
    if (v0 && v1) return pr;
    return v1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (m_init) begin
        bit any;
        bit g;
        any = req0_valid || req1_valid;
        g   = pick(req0_valid, req1_valid, m_prio);
        chk("req0_ready", req0_ready, !m_busy && any && !g);
        chk("req1_ready", req1_ready, !m_busy && any && g);
        chk("resp_valid", resp_valid, m_busy && (m_cnt == 4));
        chk("busy", busy, m_busy);
        if (m_busy && (m_cnt == 4)) begin
          chk("resp_p", resp_p, m_p);
          chk("resp_id", resp_id, m_id);
        end else if (m_zero) begin
          chk("resp_p_reset", resp_p, 0);
          chk("resp_id_reset", resp_id, 0);
        end
      end
      @(posedge clk);
      if (rst) begin
        m_init = 1'b1;
        m_busy = 1'b0;
        m_prio = 1'b0;
        m_zero = 1'b1;
      end else if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          bit g;
          g = pick(req0_valid, req1_valid, m_prio);
          m_busy = 1'b1;
          m_cnt  = 0;
          m_id   = g;
          m_prio = !g;
          m_zero = 1'b0;
          m_p    = g ? 8'(req1_a * req1_b) : 8'(req0_a * req0_b);
        end
      end else if (m_cnt < 4) begin
        m_cnt++;
      end else if (resp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_p", resp_p, 0);
    chk("rst_resp_id", resp_id, 0);
  endtask

  task automatic issue(input bit port, input logic [3:0] a, input logic [3:0] b, input string nm);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk({nm, "_ready"}, port ? req1_ready : req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called right after the accept edge; result must appear after 4 more edges
  task automatic wait_resp(input logic [7:0] ep, input logic eid, input string nm);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (n == 1) chk({nm, "_busy"}, busy, 1);
      if (resp_valid) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
      cyc();
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_latency"}, lat, 5);
      chk({nm, "_p"}, resp_p, ep);
      chk({nm, "_id"}, resp_id, eid);
    end
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int idx[$];
    int order[$];
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    logic [7:0] tp [4];
    ta = '{4'd0, 4'd15, 4'd1, 4'd15};
    tb = '{4'd15, 4'd0, 4'd1, 4'd1};
    tp = '{8'd0, 8'd0, 8'd1, 8'd15};

    do_reset();

    issue(1'b0, 4'd3, 4'd5, "single");
    wait_resp(8'd15, 1'b0, "single");

    req1_valid = 1'b1; req1_a = 4'd8; req1_b = 4'd9;
    for (int i = 0; i < 20; i++) begin
      bit hit;
      #1;
      hit = req1_ready;
      if (hit) idx.push_back(i);
      cyc();
      if (hit && idx.size() == 1) begin
        req1_a = 4'd12; req1_b = 4'd12;
      end else if (hit) begin
        req1_valid = 1'b0;
      end
    end
    chk("b2b_accepts", idx.size(), 2);
    if (idx.size() == 2) chk("b2b_spacing", idx[1] - idx[0], 6);

    // Contention from reset, repeated twice
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
    req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd12;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        bit a0;
        bit a1;
        #1;
        a0 = req0_ready;
        a1 = req1_ready;
        if (a0) order.push_back(0);
        if (a1) order.push_back(1);
        cyc();
        if (a0) req0_valid = 1'b0;
        if (a1) req1_valid = 1'b0;
      end
    end
    chk("contend_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("contend_first", order[0], 0);
      chk("contend_second", order[1], 1);
      chk("contend_third", order[2], 0);
      chk("contend_fourth", order[3], 1);
    end

    // Backpressure with a competing request held
    resp_ready = 1'b0;
    issue(1'b0, 4'd7, 4'd6, "bp");
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    wait_resp(8'd42, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_p", resp_p, 42);
      chk("bp_id", resp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    #1;
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready1", req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    wait_resp(8'd1, 1'b1, "bp_next");

    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ta[i], tb[i], "edge");
      wait_resp(tp[i], 1'b0, "edge");
    end

    // Reset while CALC is at step 2
    issue(1'b1, 4'd3, 4'd3, "midrst");
    cyc();
    cyc();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("midrst_no_resp", resp_valid, 0);
      cyc();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("midrst_prio0", req0_ready, 1);
    chk("midrst_prio1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    issue(1'b1, 4'd2, 4'd7, "after_rst");
    wait_resp(8'd14, 1'b1, "after_rst");

    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a     = 4'($urandom_range(0, 15));
      req0_b     = 4'($urandom_range(0, 15));
      req1_a     = 4'($urandom_range(0, 15));
      req1_b     = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
